psum_accum: RTL

PSUM_ACCUM -- requirements
Module: psum_accum

---
 rtl/slac_pkg.sv | 14 +
 rtl/psum_adder.sv | 29 ++
 rtl/psum_accum.sv | 117 +++++++++++
 3 files changed

// File: rtl/slac_pkg.sv
// slac_pkg: shared state encoding and default sizing for the psum accumulator
package slac_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } psum_state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_CH_WIDTH   = 8;

endpackage

// File: rtl/psum_adder.sv
// psum_adder: signed DATA_WIDTH adder; saturates when PSUM_SAT_EN is defined, wraps otherwise
module psum_adder #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] sum
);

    logic signed [DATA_WIDTH-1:0] raw;

    assign raw = a + b;

`ifdef PSUM_SAT_EN
    localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic ovf;

    // overflow only when both operands share a sign the result does not
    always_comb begin
        ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (raw[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
        sum = ovf ? (a[DATA_WIDTH-1] ? SMIN : SMAX) : raw;
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/psum_accum.sv
// psum_accum: accumulates per-position psums over channels, then drains ofmap words (PSUM_SAT_EN selects saturating adds)
module psum_accum
    import slac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CH_WIDTH   = DEF_CH_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic [$clog2(DEPTH):0]    i_num_outputs,
    input  logic [CH_WIDTH-1:0]       i_num_channels,
    input  logic [DATA_WIDTH-1:0]     i_psum_data,
    input  logic                      i_psum_valid,
    output logic [DATA_WIDTH-1:0]     o_ofmap_data,
    output logic                      o_ofmap_valid,
    input  logic                      i_ofmap_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_drop_err
);

    localparam int LOG_DEPTH = $clog2(DEPTH);
    localparam logic [LOG_DEPTH:0]   NO_ONE   = 1;
    localparam logic [LOG_DEPTH:0]   NO_DEPTH = DEPTH;
    localparam logic [LOG_DEPTH-1:0] PTR_ONE  = 1;
    localparam logic [CH_WIDTH-1:0]  CH_ONE   = 1;

    psum_state_t state, state_nxt;

    logic [LOG_DEPTH-1:0]  wr_ptr, rd_ptr;
    logic [CH_WIDTH-1:0]   ch_cnt, num_channels;
    logic [LOG_DEPTH:0]    num_outputs, last_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] addend, sum;
    logic                  done, drop_err;
    logic                  cfg_ok, accept, psum_hit, wr_last, ch_last, xfer, rd_last;

    assign cfg_ok   = (i_num_outputs != '0) && (i_num_outputs <= NO_DEPTH) && (i_num_channels != '0);
    assign accept   = (state == S_IDLE) && i_start && cfg_ok;
    assign psum_hit = (state == S_ACCUM) && i_psum_valid;
    assign last_idx = num_outputs - NO_ONE;
    assign wr_last  = {1'b0, wr_ptr} == last_idx;
    assign rd_last  = {1'b0, rd_ptr} == last_idx;
    assign ch_last  = ch_cnt == (num_channels - CH_ONE);
    assign xfer     = (state == S_DRAIN) && i_ofmap_ready;

    // channel 0 overwrites stale contents, later channels add onto the buffered sum
    assign addend = (ch_cnt == '0) ? '0 : mem[wr_ptr];

    psum_adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .a   (addend),
        .b   (i_psum_data),
        .sum (sum)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // next-state and drain-side outputs
    always_comb begin
        state_nxt     = state;
        o_busy        = state != S_IDLE;
        o_ofmap_valid = state == S_DRAIN;
        o_ofmap_data  = (state == S_DRAIN) ? mem[rd_ptr] : '0;
        case (state)
            S_IDLE:  state_nxt = accept ? S_ACCUM : S_IDLE;
            S_ACCUM: state_nxt = (psum_hit && wr_last && ch_last) ? S_DRAIN : S_ACCUM;
            S_DRAIN: state_nxt = (xfer && rd_last) ? S_IDLE : S_DRAIN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // pointers, channel counter, latched configuration and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ch_cnt       <= '0;
            num_outputs  <= '0;
            num_channels <= '0;
            done         <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            if (accept) begin
                num_outputs  <= i_num_outputs;
                num_channels <= i_num_channels;
                wr_ptr       <= '0;
                ch_cnt       <= '0;
                rd_ptr       <= '0;
            end
            if (psum_hit) begin
                wr_ptr <= wr_last ? '0 : wr_ptr + PTR_ONE;
                if (wr_last) ch_cnt <= ch_cnt + CH_ONE;
                if (wr_last && ch_last) rd_ptr <= '0;
            end
            if (xfer) rd_ptr <= rd_last ? '0 : rd_ptr + PTR_ONE;
            done     <= xfer && rd_last;
            drop_err <= drop_err | (i_psum_valid && (state != S_ACCUM));
        end
    end

    // buffer write; contents are never reset since channel 0 always writes first
    always_ff @(posedge clk) begin
        if (psum_hit) mem[wr_ptr] <= sum;
    end

    assign o_done     = done;
    assign o_drop_err = drop_err;

endmodule
